// File: rtl/axis_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_fifo_pkg : shared types and helpers for the AXI-Stream FIFO     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package axis_fifo_pkg;

  typedef enum logic {
    MODE_STREAM = 1'b0,
    MODE_PACKET = 1'b1
  } mode_e;

  // Stored entry is data, byte enables and the last flag.
  function automatic int entry_width(input int data_width);
    return data_width + (data_width / 8) + 1;
  endfunction

  function automatic logic level_ge(input int lvl, input int thresh);
    return (lvl >= thresh);
  endfunction

  function automatic logic level_le(input int lvl, input int thresh);
    return (lvl <= thresh);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pkt_fifo_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdp_ram : simple dual-port RAM, synchronous read with read enable    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sdp_ram #(
  parameter int Width     = 37,
  parameter int Depth     = 2048,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_pkt_fifo : FWFT AXI-Stream FIFO with optional store-and-forward |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DataWidth         = 32,
  parameter int Depth             = 2048,
  parameter int PacketMode        = 0,
  parameter int AlmostFullThresh  = Depth - 4,
  parameter int AlmostEmptyThresh = 4,
  localparam int KeepWidth        = DataWidth / 8,
  localparam int PtrWidth         = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DataWidth-1:0] s_axis_tdata,
  input  logic [KeepWidth-1:0] s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [DataWidth-1:0] m_axis_tdata,
  output logic [KeepWidth-1:0] m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [PtrWidth:0]    level,
  output logic [PtrWidth:0]    pkt_count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty
);

  localparam int EntryWidth           = entry_width(DataWidth);
  localparam mode_e c_MODE            = (PacketMode != 0) ? MODE_PACKET : MODE_STREAM;
  localparam logic [PtrWidth:0] c_DEPTH = (PtrWidth+1)'(Depth);
  localparam logic [PtrWidth:0] c_ONE   = (PtrWidth+1)'(1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [KeepWidth-1:0] keep;
    logic                 last;
  } entry_t;

  logic [PtrWidth:0] r_wr_ptr, r_rd_ptr, r_commit_ptr;
  logic [PtrWidth:0] r_level, r_pkt_count, w_level_nxt, w_pkt_nxt, w_ram_count;
  logic              r_out_valid, r_s_ready, r_release;
  logic              r_full, r_empty, r_afull, r_aempty;
  logic              w_wr, w_rd, w_rd_last, w_gate, w_load;
  entry_t            w_wr_entry, w_rd_entry;

  assign w_wr_entry  = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
  assign w_wr        = s_axis_tvalid & r_s_ready;
  assign w_rd        = r_out_valid & m_axis_tready;
  assign w_rd_last   = w_rd & w_rd_entry.last;
  assign w_ram_count = r_wr_ptr - r_rd_ptr;

  // Packet mode only prefetches beats up to the end of the newest complete
  // packet, unless a full FIFO forces an oversized packet to stream out.
  assign w_gate = (c_MODE == MODE_STREAM) || (r_rd_ptr != r_commit_ptr) || r_release;
  assign w_load = (w_ram_count != '0) && w_gate && (!r_out_valid || m_axis_tready);

  always_comb begin
    w_level_nxt = r_level;
    w_pkt_nxt   = r_pkt_count;
    if (w_wr && !w_rd) w_level_nxt = r_level + c_ONE;
    if (!w_wr && w_rd) w_level_nxt = r_level - c_ONE;
    if ((w_wr && s_axis_tlast) && !w_rd_last) w_pkt_nxt = r_pkt_count + c_ONE;
    if (!(w_wr && s_axis_tlast) && w_rd_last) w_pkt_nxt = r_pkt_count - c_ONE;
  end

  sdp_ram #(
    .Width     (EntryWidth),
    .Depth     (Depth),
    .AddrWidth (PtrWidth)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr),
    .waddr (r_wr_ptr[PtrWidth-1:0]),
    .wdata (w_wr_entry),
    .re    (w_load),
    .raddr (r_rd_ptr[PtrWidth-1:0]),
    .rdata (w_rd_entry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_commit_ptr <= '0;
      r_level      <= '0;
      r_pkt_count  <= '0;
      r_out_valid  <= 1'b0;
      r_s_ready    <= 1'b0;
      r_release    <= 1'b0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= 1'b0;
      r_aempty     <= 1'b1;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ONE;
        if (s_axis_tlast) r_commit_ptr <= r_wr_ptr + c_ONE;
      end
      if (w_load) r_rd_ptr <= r_rd_ptr + c_ONE;

      if (w_load)    r_out_valid <= 1'b1;
      else if (w_rd) r_out_valid <= 1'b0;

      // Release ends once the oversized packet's tlast is stored.
      if (w_wr && s_axis_tlast)
        r_release <= 1'b0;
      else if ((c_MODE == MODE_PACKET) && (r_level == c_DEPTH) && (r_rd_ptr == r_commit_ptr))
        r_release <= 1'b1;

      r_level     <= w_level_nxt;
      r_pkt_count <= w_pkt_nxt;
      r_s_ready   <= (w_level_nxt != c_DEPTH);
      r_full      <= (w_level_nxt == c_DEPTH);
      r_empty     <= (w_level_nxt == '0);
      r_afull     <= level_ge(int'(w_level_nxt), AlmostFullThresh);
      r_aempty    <= level_le(int'(w_level_nxt), AlmostEmptyThresh);
    end
  end

  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = r_out_valid ? w_rd_entry.data : '0;
  assign m_axis_tkeep  = r_out_valid ? w_rd_entry.keep : '0;
  assign m_axis_tlast  = r_out_valid & w_rd_entry.last;
  assign level         = r_level;
  assign pkt_count     = r_pkt_count;
  assign full          = r_full;
  assign empty         = r_empty;
  assign almost_full   = r_afull;
  assign almost_empty  = r_aempty;

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_pkt_fifo : scoreboard bench, stream and packet instances     |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_axis_pkt_fifo;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int DEPTH = 16;
  localparam int LW = 5;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [DW-1:0] s_tdata[2];
  logic [KW-1:0] s_tkeep[2];
  logic          s_tvalid[2], s_tready[2], s_tlast[2];
  logic [DW-1:0] m_tdata[2];
  logic [KW-1:0] m_tkeep[2];
  logic          m_tvalid[2], m_tready[2], m_tlast[2];
  logic [LW-1:0] level[2], pkt_count[2];
  logic          full[2], empty[2], afull[2], aempty[2];

  axis_pkt_fifo #(.DataWidth(DW), .Depth(DEPTH), .PacketMode(0),
                  .AlmostFullThresh(12), .AlmostEmptyThresh(4)) u_stream (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]),
    .level(level[0]), .pkt_count(pkt_count[0]), .full(full[0]), .empty(empty[0]),
    .almost_full(afull[0]), .almost_empty(aempty[0])
  );

  axis_pkt_fifo #(.DataWidth(DW), .Depth(DEPTH), .PacketMode(1),
                  .AlmostFullThresh(12), .AlmostEmptyThresh(4)) u_packet (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]),
    .level(level[1]), .pkt_count(pkt_count[1]), .full(full[1]), .empty(empty[1]),
    .almost_full(afull[1]), .almost_empty(aempty[1])
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    mon_en  = 0;
  beat_t exp_q[2][$];
  int    model_level[2];
  int    model_pkt[2];
  bit    model_rel[2];
  bit    prev_v[2], prev_r[2];
  beat_t prev_b[2];
  bit    track_lat = 0;
  int    first_acc = -1, first_val = -1, peak = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endtask

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      for (int k = 0; k < 2; k++) begin
        beat_t got, e;
        got = {m_tdata[k], m_tkeep[k], m_tlast[k]};
        chk("level", level[k], model_level[k]);
        chk("pkt_count", pkt_count[k], model_pkt[k]);
        chk("full", full[k], model_level[k] == DEPTH);
        chk("empty", empty[k], model_level[k] == 0);
        chk("almost_full", afull[k], model_level[k] >= 12);
        chk("almost_empty", aempty[k], model_level[k] <= 4);
        chk("s_tready", s_tready[k], model_level[k] < DEPTH);
        if (prev_v[k] && !prev_r[k]) begin
          chk("hold_valid", m_tvalid[k], 1);
          chk("hold_beat", got, prev_b[k]);
        end
        if (k == 1 && m_tvalid[k])
          chk("pkt_gate", (model_pkt[k] > 0) || model_rel[k], 1);
        if (k == 0 && track_lat) begin
          if (level[0] > peak) peak = level[0];
          if (first_acc < 0 && s_tvalid[0] && s_tready[0]) first_acc = cyc;
          if (first_val < 0 && m_tvalid[0]) first_val = cyc;
        end
        if (m_tvalid[k] && m_tready[k]) begin
          if (exp_q[k].size() == 0) fail_evt("no_extra_beat");
          else begin
            e = exp_q[k].pop_front();
            chk("beat", got, e);
            if (e.l) model_pkt[k]--;
          end
          model_level[k]--;
        end
        if (s_tvalid[k] && s_tready[k]) begin
          exp_q[k].push_back({s_tdata[k], s_tkeep[k], s_tlast[k]});
          model_level[k]++;
          if (s_tlast[k]) begin
            model_pkt[k]++;
            model_rel[k] = 0;
          end
        end
        if (model_level[k] == DEPTH) model_rel[k] = 1;
        prev_v[k] = m_tvalid[k];
        prev_r[k] = m_tready[k];
        prev_b[k] = got;
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      model_level[k] = 0;
      model_pkt[k] = 0;
      model_rel[k] = 0;
      prev_v[k] = 0;
      prev_r[k] = 0;
    end
  endtask

  task automatic chk_reset_vals();
    for (int k = 0; k < 2; k++) begin
      chk("rst_s_tready", s_tready[k], 0);
      chk("rst_m_tvalid", m_tvalid[k], 0);
      chk("rst_m_tlast", m_tlast[k], 0);
      chk("rst_m_tdata", {m_tdata[k], m_tkeep[k]}, 0);
      chk("rst_level", level[k], 0);
      chk("rst_pkt_count", pkt_count[k], 0);
      chk("rst_flags", {full[k], empty[k], afull[k], aempty[k]}, 4'b0101);
    end
  endtask

  task automatic send(input int k, input logic [DW-1:0] d, input logic [KW-1:0] kp, input logic l);
    int t;
    bit done;
    t = 0;
    done = 0;
    s_tvalid[k] = 1; s_tdata[k] = d; s_tkeep[k] = kp; s_tlast[k] = l;
    while (!done) begin
      @(negedge clk);
      if (s_tready[k]) done = 1;
      @(posedge clk); #1;
      t++;
      if (!done && t > 60) begin
        fail_evt("send_timeout");
        done = 1;
      end
    end
    s_tvalid[k] = 0; s_tlast[k] = 0;
  endtask

  task automatic wait_drain(input int k);
    bit done;
    done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk); #2;
      if (exp_q[k].size() == 0 && level[k] == 0 && !m_tvalid[k]) done = 1;
    end
    if (!done) fail_evt("drain_timeout");
    chk("drain_empty", empty[k], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc[2];
    bit open[2];
    int idx;
    for (int k = 0; k < 2; k++) begin
      s_tvalid[k] = 0; s_tdata[k] = '0; s_tkeep[k] = '0; s_tlast[k] = 0; m_tready[k] = 0;
    end
    clear_model();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    reset_n = 1;
    @(posedge clk); #1;
    chk("ready_after_reset0", s_tready[0], 1);
    chk("ready_after_reset1", s_tready[1], 1);
    mon_en = 1;

    // Stream: 10 back-to-back beats, consumer always ready.
    m_tready[0] = 1;
    track_lat = 1;
    for (int i = 0; i < 10; i++) send(0, DW'(i), 4'hF, i == 9);
    wait_drain(0);
    track_lat = 0;
    chk("latency", first_val - first_acc, 2);
    chk("level_peak", peak, 2);

    // Stream: fill to capacity with consumer stalled.
    m_tready[0] = 0;
    idx = 0;
    s_tvalid[0] = 1;
    for (int c = 0; c < 24; c++) begin
      s_tdata[0] = 32'h100 + DW'(idx); s_tkeep[0] = 4'hF; s_tlast[0] = (idx % 5 == 4);
      @(negedge clk);
      if (s_tready[0]) idx++;
      @(posedge clk); #1;
    end
    s_tvalid[0] = 0; s_tlast[0] = 0;
    chk("accepts_at_full", idx, 16);
    chk("full_level", level[0], 16);
    chk("full_flag", full[0], 1);
    chk("full_tready", s_tready[0], 0);
    m_tready[0] = 1;
    @(posedge clk); #1;
    m_tready[0] = 0;
    chk("tready_after_read", s_tready[0], 1);
    m_tready[0] = 1;
    wait_drain(0);

    // Packet: 5 beats, gap before tlast, output must stay idle.
    m_tready[1] = 1;
    for (int i = 0; i < 4; i++) send(1, 32'hA0 + DW'(i), 4'hF, 0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("pkt_hold_valid", m_tvalid[1], 0);
      @(posedge clk); #1;
    end
    send(1, 32'hA4, 4'h3, 1);
    chk("pkt_count_one", pkt_count[1], 1);
    wait_drain(1);

    // Packet: 20-beat packet exceeds capacity, must release.
    for (int i = 0; i < 20; i++) send(1, 32'hB00 + DW'(i), 4'(i), i == 19);
    wait_drain(1);

    // Random concurrent traffic around half full.
    m_tready[0] = 0; m_tready[1] = 0;
    for (int i = 0; i < 8; i++) begin
      send(0, 32'hC00 + DW'(i), 4'hF, i == 7);
      send(1, 32'hD00 + DW'(i), 4'hF, (i == 3) || (i == 7));
    end
    acc[0] = 0; acc[1] = 0; open[0] = 0; open[1] = 0;
    for (int c = 0; c < 100; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!s_tvalid[k] || acc[k]) begin
          s_tvalid[k] = ($urandom_range(0, 3) != 0);
          s_tdata[k]  = $urandom;
          s_tkeep[k]  = 4'($urandom);
          s_tlast[k]  = ($urandom_range(0, 3) == 0);
        end
        m_tready[k] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        acc[k] = s_tvalid[k] && s_tready[k];
        if (acc[k]) open[k] = !s_tlast[k];
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      s_tvalid[k] = 0; s_tlast[k] = 0; m_tready[k] = 1;
    end
    if (open[1]) send(1, 32'hC105E, 4'hF, 1);
    wait_drain(0);
    wait_drain(1);

    // Reset mid-packet at level 7.
    m_tready[1] = 0;
    for (int i = 0; i < 7; i++) send(1, 32'hE00 + DW'(i), 4'hF, 0);
    chk("pre_reset_level", level[1], 7);
    mon_en = 0;
    #2 reset_n = 0;
    #1 chk_reset_vals();
    clear_model();
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    mon_en = 1;
    m_tready[1] = 1;
    for (int i = 0; i < 3; i++) send(1, 32'hF00 + DW'(i), 4'h7, i == 2);
    wait_drain(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
